// File: rtl/velocity_cell_dbuf.sv
// velocity_cell_dbuf: double-buffered per-cell velocity memory.
// Reads come from the active bank and writes go to the shadow bank. A swap
// handshake exchanges the two banks once the writer pauses.
// Optional feature macro: VELOCITY_WR_CHECK_EN. When it is defined, an
// out-of-range write or read raises the sticky wr_err flag.
module velocity_cell_dbuf #(
  parameter int COMP_WIDTH   = 32,
  parameter int DATA_WIDTH   = 3*COMP_WIDTH,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  swap_req,
  output logic                  swap_ack,
  output logic                  active_bank,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic                  wr_err
);

  localparam logic [ADDR_WIDTH:0] PN_LIMIT = (ADDR_WIDTH+1)'(PARTICLE_NUM);
  localparam logic [ADDR_WIDTH:0] WRC_MAX  = '1;

  typedef enum logic [1:0] {IDLE, PEND, ACK} swap_state_t;

  // Address lies inside the bank (address 0 is the count word, still in range).
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < PN_LIMIT;
  endfunction

  // Saturating increment for the shadow write counter.
  function automatic logic [ADDR_WIDTH:0] sat_inc(input logic [ADDR_WIDTH:0] v);
    return (v == WRC_MAX) ? v : v + 1'b1;
  endfunction

  logic [DATA_WIDTH-1:0] mem [2][PARTICLE_NUM];
  logic [ADDR_WIDTH-1:0] cnt_q [2];
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd_data_p1;
  logic                  vld_p1;
  logic                  shadow;
  logic                  wr_word;
  logic                  wr_cnt_ld;
  logic                  swap_fire;
  swap_state_t           state_q, state_d;

  assign shadow         = ~active_bank;
  assign wr_word        = wr_en && (wr_addr != '0) && addr_ok(wr_addr);
  assign wr_cnt_ld      = wr_en && (wr_addr == '0);
  assign particle_count = cnt_q[active_bank];
  assign swap_ack       = (state_q == ACK);
  assign rd_data        = rd_data_p1;
  assign rd_valid       = vld_p1;

  // Velocity storage: shadow-bank writes only, contents are never reset.
  always_ff @(posedge clock) begin
    if (wr_word) mem[shadow][wr_addr] <= wr_data;
  end

  // Read mux: address 0 returns the count word, out-of-range returns zero.
  always_comb begin
    rd_word = '0;
    if (rd_addr == '0)
      rd_word = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, particle_count};
    else if (addr_ok(rd_addr))
      rd_word = mem[active_bank][rd_addr];
  end

  // Stage p0 -> p1: registered read data and valid; data holds between reads.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= rd_en;
      if (rd_en) rd_data_p1 <= rd_word;
    end
  end

  // Per-bank particle count registers, loaded through shadow address 0.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else if (wr_cnt_ld) begin
      cnt_q[shadow] <= wr_data[ADDR_WIDTH-1:0];
    end
  end

  // Swap FSM state register.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Swap FSM next state: PEND waits for a write-free cycle before exchanging.
  always_comb begin
    state_d   = state_q;
    swap_fire = 1'b0;
    case (state_q)
      IDLE: if (swap_req) state_d = PEND;
      PEND: if (!wr_en) begin
        swap_fire = 1'b1;
        state_d   = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bank selector and shadow write counter; the swap never coincides with a write.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      active_bank <= 1'b0;
      wr_count    <= '0;
    end else if (swap_fire) begin
      active_bank <= ~active_bank;
      wr_count    <= '0;
    end else if (wr_word) begin
      wr_count <= sat_inc(wr_count);
    end
  end

`ifdef VELOCITY_WR_CHECK_EN
  // Sticky range-error flag for writes and reads beyond the bank.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) wr_err <= 1'b0;
    else if ((wr_en && !addr_ok(wr_addr)) || (rd_en && !addr_ok(rd_addr)))
      wr_err <= 1'b1;
  end
`else
  assign wr_err = 1'b0;
`endif

endmodule

// File: tb/tb_velocity_cell_dbuf.sv
// Testbench for velocity_cell_dbuf: directed scenarios plus randomized traffic
// checked against a behavioural bank/count/handshake model.
module tb_velocity_cell_dbuf;
  localparam int AW = 8;
  localparam int DW = 96;
  localparam int PN = 220;
`ifdef VELOCITY_WR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          rst = 1'b1;
  logic          rd_en = 1'b0, wr_en = 1'b0, swap_req = 1'b0;
  logic [AW-1:0] rd_addr = '0, wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid, swap_ack, active_bank, wr_err;
  logic [AW-1:0] particle_count;
  logic [AW:0]   wr_count;

  int n_checks = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  velocity_cell_dbuf dut (
    .clock(clock), .rst(rst),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .swap_req(swap_req), .swap_ack(swap_ack), .active_bank(active_bank),
    .particle_count(particle_count), .wr_count(wr_count), .wr_err(wr_err)
  );

  // Reference model state
  logic [DW-1:0] m_mem [2][PN];
  bit            m_known [2][PN];
  logic [AW-1:0] m_cnt [2];
  bit            m_act, m_err, m_pend, m_ack, m_vld, m_rd_known;
  int            m_wrc;
  logic [DW-1:0] m_rd;

  task automatic model_reset();
    m_act = 0; m_cnt[0] = '0; m_cnt[1] = '0; m_wrc = 0; m_err = 0;
    m_pend = 0; m_ack = 0; m_rd = '0; m_rd_known = 1; m_vld = 0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    bit old_act, sh, was_pend, was_ack;
    if (rst) begin
      model_reset();
      return;
    end
    old_act = m_act; sh = ~m_act; was_pend = m_pend; was_ack = m_ack;
    m_vld = rd_en;
    if (rd_en) begin
      if (rd_addr == 0) begin
        m_rd = DW'(m_cnt[old_act]); m_rd_known = 1;
      end else if (int'(rd_addr) >= PN) begin
        m_rd = '0; m_rd_known = 1;
      end else begin
        m_rd = m_mem[old_act][rd_addr]; m_rd_known = m_known[old_act][rd_addr];
      end
    end
    if (CHK && ((rd_en && int'(rd_addr) >= PN) || (wr_en && int'(wr_addr) >= PN))) m_err = 1;
    if (wr_en) begin
      if (wr_addr == 0) m_cnt[sh] = wr_data[AW-1:0];
      else if (int'(wr_addr) < PN) begin
        m_mem[sh][wr_addr] = wr_data;
        m_known[sh][wr_addr] = 1;
        if (m_wrc < 511) m_wrc++;
      end
    end
    m_ack = 0;
    if (was_pend && !wr_en) begin
      m_act = ~m_act; m_wrc = 0; m_pend = 0; m_ack = 1;
    end else if (!was_pend && !was_ack && swap_req) begin
      m_pend = 1;
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc();
    n_checks++; if (rd_data !== '0) begin n_err++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
    n_checks++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    n_checks++; if (swap_ack !== 1'b0) begin n_err++; $display("FAIL reset_swap_ack got %b want 0", swap_ack); end
    n_checks++; if (active_bank !== 1'b0) begin n_err++; $display("FAIL reset_active_bank got %b want 0", active_bank); end
    n_checks++; if (particle_count !== '0) begin n_err++; $display("FAIL reset_particle_count got %0d want 0", particle_count); end
    n_checks++; if (wr_count !== '0) begin n_err++; $display("FAIL reset_wr_count got %0d want 0", wr_count); end
    n_checks++; if (wr_err !== 1'b0) begin n_err++; $display("FAIL reset_wr_err got %b want 0", wr_err); end
    rst = 1'b0;
    rd_en = 1'b1; rd_addr = 8'd0;
    cyc();
    rd_en = 1'b0;
    n_checks++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL rd0_valid got %b want 1", rd_valid); end
    n_checks++; if (rd_data !== '0) begin n_err++; $display("FAIL rd0_data got %h want 0", rd_data); end
    cyc();
    n_checks++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rd_valid_single got %b want 0", rd_valid); end
  endtask

  task automatic test_swap_basic();
    wr_en = 1'b1; wr_addr = 8'd0; wr_data = DW'(5);
    cyc();
    for (int a = 1; a <= 5; a++) begin
      wr_addr = AW'(a); wr_data = {3{32'h3F800000}};
      cyc();
    end
    wr_en = 1'b0;
    n_checks++; if (wr_count !== 9'd5) begin n_err++; $display("FAIL basic_wr_count got %0d want 5", wr_count); end
    swap_req = 1'b1;
    cyc();
    swap_req = 1'b0;
    n_checks++; if (swap_ack !== 1'b0 || active_bank !== 1'b0) begin n_err++; $display("FAIL basic_pend got ack=%b bank=%b want 0/0", swap_ack, active_bank); end
    cyc();
    n_checks++; if (swap_ack !== 1'b1) begin n_err++; $display("FAIL basic_swap_ack got %b want 1", swap_ack); end
    n_checks++; if (active_bank !== 1'b1) begin n_err++; $display("FAIL basic_active_bank got %b want 1", active_bank); end
    n_checks++; if (particle_count !== 8'd5) begin n_err++; $display("FAIL basic_particle_count got %0d want 5", particle_count); end
    n_checks++; if (wr_count !== 9'd0) begin n_err++; $display("FAIL basic_wr_count_clr got %0d want 0", wr_count); end
    rd_en = 1'b1; rd_addr = 8'd3;
    cyc();
    rd_en = 1'b0;
    n_checks++; if (swap_ack !== 1'b0) begin n_err++; $display("FAIL basic_ack_pulse got %b want 0", swap_ack); end
    n_checks++; if (rd_data !== {3{32'h3F800000}} || rd_valid !== 1'b1) begin n_err++; $display("FAIL basic_read3 got %h/%b want %h/1", rd_data, rd_valid, {3{32'h3F800000}}); end
  endtask

  task automatic test_swap_during_writes();
    logic [DW-1:0] d [5];
    for (int i = 0; i < 5; i++) d[i] = {$urandom(), $urandom(), $urandom()};
    swap_req = 1'b1; wr_en = 1'b1; wr_addr = 8'd10; wr_data = d[0];
    cyc();
    swap_req = 1'b0;
    for (int i = 1; i < 5; i++) begin
      wr_addr = AW'(10 + i); wr_data = d[i];
      cyc();
      n_checks++; if (active_bank !== 1'b1 || swap_ack !== 1'b0) begin n_err++; $display("FAIL hold_swap_%0d got bank=%b ack=%b want 1/0", i, active_bank, swap_ack); end
    end
    wr_en = 1'b0;
    cyc();
    n_checks++; if (active_bank !== 1'b0 || swap_ack !== 1'b1) begin n_err++; $display("FAIL hold_toggle got bank=%b ack=%b want 0/1", active_bank, swap_ack); end
    n_checks++; if (wr_count !== 9'd0 || particle_count !== 8'd0) begin n_err++; $display("FAIL hold_counts got wc=%0d pc=%0d want 0/0", wr_count, particle_count); end
    for (int i = 0; i < 5; i++) begin
      rd_en = 1'b1; rd_addr = AW'(10 + i);
      cyc();
      n_checks++; if (rd_data !== d[i]) begin n_err++; $display("FAIL hold_read_%0d got %h want %h", 10 + i, rd_data, d[i]); end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_read_on_toggle();
    logic [DW-1:0] x, old;
    old = m_mem[0][11];
    x = {$urandom(), $urandom(), $urandom()};
    wr_en = 1'b1; wr_addr = 8'd11; wr_data = x;
    cyc();
    wr_en = 1'b0; swap_req = 1'b1;
    cyc();
    swap_req = 1'b0; rd_en = 1'b1; rd_addr = 8'd11;
    cyc();
    n_checks++; if (rd_data !== old || active_bank !== 1'b1) begin n_err++; $display("FAIL toggle_read_old got %h bank=%b want %h bank=1", rd_data, active_bank, old); end
    cyc();
    rd_en = 1'b0;
    n_checks++; if (rd_data !== x) begin n_err++; $display("FAIL toggle_read_new got %h want %h", rd_data, x); end
  endtask

  task automatic test_out_of_range();
    wr_en = 1'b1; wr_addr = 8'd230; wr_data = {$urandom(), $urandom(), $urandom()};
    cyc();
    n_checks++; if (wr_count !== 9'd0) begin n_err++; $display("FAIL oor230_wr_count got %0d want 0", wr_count); end
    n_checks++; if (wr_err !== CHK) begin n_err++; $display("FAIL oor230_wr_err got %b want %b", wr_err, CHK); end
    wr_addr = 8'd220;
    cyc();
    n_checks++; if (wr_count !== 9'd0) begin n_err++; $display("FAIL oor220_wr_count got %0d want 0", wr_count); end
    wr_addr = 8'd219;
    cyc();
    wr_en = 1'b0;
    n_checks++; if (wr_count !== 9'd1) begin n_err++; $display("FAIL last_addr_wr_count got %0d want 1", wr_count); end
    rd_en = 1'b1; rd_addr = 8'd225;
    cyc();
    rd_en = 1'b0;
    n_checks++; if (rd_data !== '0 || rd_valid !== 1'b1) begin n_err++; $display("FAIL oor_read got %h/%b want 0/1", rd_data, rd_valid); end
  endtask

  task automatic test_reset_in_pend();
    swap_req = 1'b1; wr_en = 1'b1; wr_addr = 8'd5; wr_data = {$urandom(), $urandom(), $urandom()};
    cyc();
    swap_req = 1'b0;
    #2 rst = 1'b1;
    #1 model_reset();
    wr_en = 1'b0;
    n_checks++; if (active_bank !== 1'b0 || wr_count !== 9'd0 || swap_ack !== 1'b0 || wr_err !== 1'b0) begin n_err++; $display("FAIL rst_pend got bank=%b wc=%0d ack=%b err=%b want 0/0/0/0", active_bank, wr_count, swap_ack, wr_err); end
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++; if (swap_ack !== 1'b0 || active_bank !== 1'b0) begin n_err++; $display("FAIL rst_pend_noack_%0d got ack=%b bank=%b want 0/0", i, swap_ack, active_bank); end
    end
    swap_req = 1'b1;
    cyc();
    swap_req = 1'b0;
    cyc();
    n_checks++; if (swap_ack !== 1'b1 || active_bank !== 1'b1) begin n_err++; $display("FAIL rst_pend_reswap got ack=%b bank=%b want 1/1", swap_ack, active_bank); end
  endtask

  task automatic test_wr_count_sat();
    wr_en = 1'b1; wr_addr = 8'd1;
    for (int i = 0; i < 520; i++) begin
      wr_data = {$urandom(), $urandom(), $urandom()};
      cyc();
    end
    wr_en = 1'b0;
    n_checks++; if (wr_count !== 9'd511) begin n_err++; $display("FAIL wr_count_sat got %0d want 511", wr_count); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      rd_en    = ($urandom_range(0, 1) == 1);
      rd_addr  = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(0, 255)) : AW'($urandom_range(0, 15));
      wr_en    = ($urandom_range(0, 9) < 6);
      wr_addr  = ($urandom_range(0, 11) == 0) ? AW'($urandom_range(200, 255)) : AW'($urandom_range(0, 15));
      wr_data  = {$urandom(), $urandom(), $urandom()};
      swap_req = ($urandom_range(0, 7) == 0);
      cyc();
      n_checks++; if (rd_valid !== m_vld) begin n_err++; $display("FAIL rnd_rd_valid@%0d got %b want %b", i, rd_valid, m_vld); end
      if (m_rd_known) begin
        n_checks++; if (rd_data !== m_rd) begin n_err++; $display("FAIL rnd_rd_data@%0d got %h want %h", i, rd_data, m_rd); end
      end
      n_checks++; if (swap_ack !== m_ack) begin n_err++; $display("FAIL rnd_swap_ack@%0d got %b want %b", i, swap_ack, m_ack); end
      n_checks++; if (active_bank !== m_act) begin n_err++; $display("FAIL rnd_active_bank@%0d got %b want %b", i, active_bank, m_act); end
      n_checks++; if (particle_count !== m_cnt[m_act]) begin n_err++; $display("FAIL rnd_particle_count@%0d got %0d want %0d", i, particle_count, m_cnt[m_act]); end
      n_checks++; if (wr_count !== 9'(m_wrc)) begin n_err++; $display("FAIL rnd_wr_count@%0d got %0d want %0d", i, wr_count, m_wrc); end
      n_checks++; if (wr_err !== m_err) begin n_err++; $display("FAIL rnd_wr_err@%0d got %b want %b", i, wr_err, m_err); end
    end
    rd_en = 1'b0; wr_en = 1'b0; swap_req = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_swap_basic();
    test_swap_during_writes();
    test_read_on_toggle();
    test_out_of_range();
    test_reset_in_pend();
    test_wr_count_sat();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
